// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN dynamic M/D reprogramming sequencer.
package dcm_prog_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_D,
        GAP1,
        LOAD_M,
        GAP2,
        GO,
        GO_GAP,
        WAIT_DONE,
        WAIT_LOCK
    } state_e;

    // Command prefixes, transmitted bit0 first ahead of the 8-bit value.
    localparam logic [1:0] CMD_LOADD   = 2'b01;
    localparam logic [1:0] CMD_LOADM   = 2'b11;
    localparam logic [7:0] RST_MULT_M1 = 8'd19;

    localparam logic [3:0] LOAD_BITS_M1 = 4'd9;
    localparam logic [3:0] GAP_BITS_M1  = 4'd1;

    function automatic logic [9:0] cmd_word(input logic [1:0] cmd, input logic [7:0] val);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/dcm_prog_shifter.sv
// 10-bit LSB-first shift register holding one LoadD/LoadM command word.
module dcm_prog_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [9:0] load_val,
    input  logic       shift_en,
    output logic       bit_out
);

    logic [9:0] sr_q;
    logic [9:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift_en) begin
            sr_d = {1'b0, sr_q[9:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_out = sr_q[0];

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Sequences LoadD, LoadM and GO on the DCM_CLKGEN PROG port, then waits for PROGDONE and LOCKED.
//   state     | meaning
//   IDLE      | waiting for start; range check on mult_m1
//   LOAD_D    | 10 bits: prefix 1,0 then div_m1 LSB first, prog_en=1
//   GAP1      | 2 idle bits
//   LOAD_M    | 10 bits: prefix 1,1 then mult_m1 LSB first, prog_en=1
//   GAP2      | 2 idle bits
//   GO        | GO bit (prog_en=1, data=0)
//   GO_GAP    | one idle bit after GO
//   WAIT_DONE | waiting for synced prog_done, timeout running
//   WAIT_LOCK | waiting for synced dcm_locked, timeout running
module dcm_prog_ctrl #(
    parameter int          PROG_DIV    = 4,
    parameter logic [7:0]  MAX_MULT_M1 = 8'd31,
    parameter logic [19:0] TIMEOUT     = 20'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mult_m1,
    input  logic [7:0] div_m1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] cur_mult_m1,
    output logic       prog_clk,
    output logic       prog_data,
    output logic       prog_en,
    input  logic       prog_done,
    input  logic       dcm_locked
);

    import dcm_prog_pkg::*;

    localparam logic [7:0] DIV_RELOAD = 8'(PROG_DIV - 1);

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [19:0] tmr_q, tmr_d;
    logic        prog_clk_q, prog_clk_d;
    logic        prog_data_q, prog_data_d;
    logic        prog_en_q, prog_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  mult_q, mult_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cur_mult_q, cur_mult_d;
    logic        pdone_meta_q, pdone_meta_d, pdone_sync_q, pdone_sync_d;
    logic        lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic        fall;
    logic        sh_load, sh_shift, sh_bit;
    logic [9:0]  sh_val;

    dcm_prog_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .load_val (sh_val),
        .shift_en (sh_shift),
        .bit_out  (sh_bit)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        tmr_d        = tmr_q;
        prog_clk_d   = prog_clk_q;
        prog_data_d  = prog_data_q;
        prog_en_d    = prog_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mult_d       = mult_q;
        div_d        = div_q;
        cur_mult_d   = cur_mult_q;
        pdone_meta_d = prog_done;
        pdone_sync_d = pdone_meta_q;
        lock_meta_d  = dcm_locked;
        lock_sync_d  = lock_meta_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_val       = cmd_word(CMD_LOADD, div_m1);
        fall         = 1'b0;

        if (div_cnt_q == 8'd0) begin
            div_cnt_d  = DIV_RELOAD;
            prog_clk_d = ~prog_clk_q;
            fall       = prog_clk_q;
        end else begin
            div_cnt_d = div_cnt_q - 8'd1;
        end

        if (tmr_q != 20'd0) begin
            tmr_d = tmr_q - 20'd1;
        end

        if (state_q == IDLE) begin
            if (start) begin
                if (mult_m1 == 8'd0 || mult_m1 > MAX_MULT_M1) begin
                    err_d = 1'b1;
                end else begin
                    mult_d    = mult_m1;
                    div_d     = div_m1;
                    busy_d    = 1'b1;
                    sh_load   = 1'b1;
                    bit_cnt_d = LOAD_BITS_M1;
                    state_d   = LOAD_D;
                end
            end
        end else if (fall) begin
            // Each state emits one wire bit per falling prog_clk; the last bit hands over.
            if (bit_cnt_q != 4'd0) begin
                bit_cnt_d = bit_cnt_q - 4'd1;
            end
            case (state_q)
                LOAD_D, LOAD_M: begin
                    prog_en_d   = 1'b1;
                    prog_data_d = sh_bit;
                    sh_shift    = 1'b1;
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = GAP_BITS_M1;
                        if (state_q == LOAD_D) begin
                            state_d = GAP1;
                        end else begin
                            state_d = GAP2;
                        end
                    end
                end
                GAP1: begin
                    prog_en_d   = 1'b0;
                    prog_data_d = 1'b0;
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = LOAD_BITS_M1;
                        sh_load   = 1'b1;
                        sh_val    = cmd_word(CMD_LOADM, mult_q);
                        state_d   = LOAD_M;
                    end
                end
                GAP2: begin
                    prog_en_d   = 1'b0;
                    prog_data_d = 1'b0;
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd0;
                        state_d   = GO;
                    end
                end
                GO: begin
                    prog_en_d   = 1'b1;
                    prog_data_d = 1'b0;
                    state_d     = GO_GAP;
                end
                GO_GAP: begin
                    prog_en_d   = 1'b0;
                    prog_data_d = 1'b0;
                    tmr_d       = TIMEOUT - 20'd1;
                    state_d     = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (pdone_sync_q) begin
                        state_d = WAIT_LOCK;
                    end else if (tmr_q == 20'd0) begin
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        prog_en_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync_q) begin
                        cur_mult_d = mult_q;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else if (tmr_q == 20'd0) begin
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        prog_en_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            div_cnt_q    <= 8'd0;
            tmr_q        <= 20'd0;
            prog_clk_q   <= 1'b0;
            prog_data_q  <= 1'b0;
            prog_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mult_q       <= 8'd0;
            div_q        <= 8'd0;
            cur_mult_q   <= RST_MULT_M1;
            pdone_meta_q <= 1'b0;
            pdone_sync_q <= 1'b0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            tmr_q        <= tmr_d;
            prog_clk_q   <= prog_clk_d;
            prog_data_q  <= prog_data_d;
            prog_en_q    <= prog_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mult_q       <= mult_d;
            div_q        <= div_d;
            cur_mult_q   <= cur_mult_d;
            pdone_meta_q <= pdone_meta_d;
            pdone_sync_q <= pdone_sync_d;
            lock_meta_q  <= lock_meta_d;
            lock_sync_q  <= lock_sync_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cur_mult_m1 = cur_mult_q;
    assign prog_clk    = prog_clk_q;
    assign prog_data   = prog_data_q;
    assign prog_en     = prog_en_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a small behavioural DCM responding to the GO command.
module tb_dcm_prog_ctrl;

    localparam int          PROG_DIV = 2;
    localparam logic [19:0] TIMEOUT  = 20'd500;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mult_m1 = 8'd0;
    logic [7:0] div_m1 = 8'd0;
    logic       busy, done, err, prog_clk, prog_data, prog_en;
    logic [7:0] cur_mult_m1;
    logic       prog_done = 1'b0;
    logic       dcm_locked = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    dcm_prog_ctrl #(
        .PROG_DIV    (PROG_DIV),
        .MAX_MULT_M1 (8'd31),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mult_m1     (mult_m1),
        .div_m1      (div_m1),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_mult_m1 (cur_mult_m1),
        .prog_clk    (prog_clk),
        .prog_data   (prog_data),
        .prog_en     (prog_en),
        .prog_done   (prog_done),
        .dcm_locked  (dcm_locked)
    );

    always #5 clk = ~clk;

    // Monitor and DCM model, sampled on the falling clk edge.
    int          cyc = 0;
    logic        pc_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0, busy_prev = 1'b0;
    logic [31:0] cap_bits = '0;
    int          cap_n = 0;
    logic [31:0] en_bits = '0;
    int          en_n = 0;
    int          runlen = 0, go_cnt = 0, pd_cnt = 0, lk_cnt = 0;
    int          go_end_cyc = 0, err_cyc = 0;
    int          done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, en_cnt = 0;
    bit          model_en = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            runlen = 0;
            pd_cnt = 0;
            lk_cnt = 0;
            cap_n  = 0;
            en_n   = 0;
        end else begin
            if (busy && !busy_prev) begin
                cap_n = 0; cap_bits = '0;
                en_n  = 0; en_bits  = '0;
            end
            if (lk_cnt > 0) begin
                lk_cnt--;
                if (lk_cnt == 0) dcm_locked = 1'b1;
            end
            if (prog_clk && !pc_prev) begin
                if (prog_en && cap_n < 32) begin
                    cap_bits[cap_n] = prog_data;
                    cap_n++;
                end
                if (en_n < 26 && (en_n > 0 || prog_en)) begin
                    en_bits[en_n] = prog_en;
                    en_n++;
                end
                if (pd_cnt > 0) begin
                    pd_cnt--;
                    if (pd_cnt == 0 && model_en) begin
                        prog_done = 1'b1;
                        lk_cnt    = 10;
                    end
                end
                if (prog_en) begin
                    if (runlen == 0) begin
                        prog_done  = 1'b0;
                        dcm_locked = 1'b0;
                    end
                    runlen++;
                end else begin
                    if (runlen == 1) begin
                        go_cnt++;
                        go_end_cyc = cyc;
                        pd_cnt     = 2;
                    end
                    runlen = 0;
                end
            end
        end
        if (prog_en) en_cnt++;
        if (done) begin
            if (!done_prev) done_cnt++; else wide_cnt++;
        end
        if (err) begin
            if (!err_prev) begin err_cnt++; err_cyc = cyc; end
            else wide_cnt++;
        end
        if (done && err) both_cnt++;
        pc_prev   = prog_clk;
        done_prev = done;
        err_prev  = err;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic [7:0] d);
        mult_m1 = m;
        div_m1  = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    endtask

    int d0, e0, g0, n0;

    initial begin
        // Reset values
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_prog_en", prog_en, 1'b0);
        check("rst_prog_clk", prog_clk, 1'b0);
        check("rst_prog_data", prog_data, 1'b0);
        check("rst_cur_mult", cur_mult_m1, 8'd19);
        reset = 1'b1;
        tick(2);

        // M-1=19, D-1=5: full serial stream, one GO, done
        d0 = done_cnt; g0 = go_cnt;
        pulse_start(8'd19, 8'd5);
        check("t1_busy_on", busy, 1'b1);
        wait_done(d0, 2000);
        check("t1_done_cnt", done_cnt, d0 + 1);
        check("t1_busy_off", busy, 1'b0);
        check("t1_bit_count", cap_n, 21);
        check("t1_stream", cap_bits[20:0], {1'b0, 10'b0001001111, 10'b0000010101});
        check("t1_en_pattern", en_bits[25:0], 26'b01_00_1111111111_00_1111111111);
        check("t1_go_cnt", go_cnt, g0 + 1);
        check("t1_cur_mult", cur_mult_m1, 8'd19);

        // Out-of-range multipliers rejected
        e0 = err_cnt; n0 = en_cnt;
        pulse_start(8'd0, 8'd0);
        check("rej0_err", err, 1'b1);
        check("rej0_busy", busy, 1'b0);
        tick();
        check("rej0_err_width", err, 1'b0);
        pulse_start(8'd40, 8'd3);
        check("rej40_err", err, 1'b1);
        check("rej40_busy", busy, 1'b0);
        tick(20);
        check("rej_err_cnt", err_cnt, e0 + 2);
        check("rej_no_prog_en", en_cnt, n0);
        check("rej_busy_idle", busy, 1'b0);

        // DCM never answers: timeout err TIMEOUT cycles after the GO bit ends,
        // which is PROG_DIV cycles before the rising edge that shows the gap bit
        model_en = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'd7, 8'd3);
        for (int i = 0; i < 3000 && err_cnt == e0; i++) tick();
        check("to_err_cnt", err_cnt, e0 + 1);
        check("to_latency", err_cyc - go_end_cyc, int'(TIMEOUT) - PROG_DIV);
        check("to_busy", busy, 1'b0);
        check("to_prog_en", prog_en, 1'b0);
        check("to_cur_mult", cur_mult_m1, 8'd19);
        check("to_no_done", done_cnt, d0);
        model_en = 1'b1;
        tick(5);

        // Second start during LOAD_M ignored
        d0 = done_cnt; g0 = go_cnt;
        pulse_start(8'd19, 8'd5);
        for (int i = 0; i < 1000 && cap_n < 12; i++) tick();
        check("ign_reached_loadm", cap_n >= 12, 1'b1);
        pulse_start(8'd30, 8'd1);
        wait_done(d0, 2000);
        check("ign_done_cnt", done_cnt, d0 + 1);
        check("ign_bit_count", cap_n, 21);
        check("ign_stream", cap_bits[20:0], {1'b0, 10'b0001001111, 10'b0000010101});
        check("ign_go_cnt", go_cnt, g0 + 1);
        check("ign_cur_mult", cur_mult_m1, 8'd19);
        tick(200);
        check("ign_no_extra_done", done_cnt, d0 + 1);
        check("ign_busy_idle", busy, 1'b0);

        // Reset during LOAD_D bit 6
        pulse_start(8'd12, 8'd4);
        for (int i = 0; i < 1000 && cap_n < 7; i++) tick();
        check("rmid_reached_bit6", cap_n, 7);
        check("rmid_en_before", prog_en, 1'b1);
        reset = 1'b0;
        #1;
        check("rmid_prog_en", prog_en, 1'b0);
        check("rmid_busy", busy, 1'b0);
        check("rmid_prog_clk", prog_clk, 1'b0);
        check("rmid_prog_data", prog_data, 1'b0);
        check("rmid_cur_mult", cur_mult_m1, 8'd19);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Back-to-back requests 10 then 25
        d0 = done_cnt;
        pulse_start(8'd10, 8'd2);
        wait_done(d0, 2000);
        check("b2b1_done_cnt", done_cnt, d0 + 1);
        check("b2b1_stream", cap_bits[20:0], {1'b0, 10'b0000101011, 10'b0000001001});
        check("b2b1_cur_mult", cur_mult_m1, 8'd10);
        pulse_start(8'd25, 8'd9);
        check("b2b2_busy_on", busy, 1'b1);
        wait_done(d0 + 1, 2000);
        check("b2b2_done_cnt", done_cnt, d0 + 2);
        check("b2b2_stream", cap_bits[20:0], {1'b0, 10'b0001100111, 10'b0000100101});
        check("b2b2_cur_mult", cur_mult_m1, 8'd25);

        tick(5);
        check("never_done_and_err", both_cnt, 0);
        check("pulse_width_one", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcm_prog_ctrl.md
Name: dcm_prog_ctrl

Overview:
- Sequencer that reprograms the DCM_CLKGEN hash clock at run time (dynamic M/D) over its PROGCLK/PROGDATA/PROGEN port.
- Replaces host bit-banging of the three DCM programming pins. Runs on the fixed fxclk domain, takes a single-cycle start request with new multiplier/divider values, and sequences LoadD, LoadM and GO.
- Waits for PROGDONE and LOCKED, then reports done or error (timeout/range).

Parameters:
PROG_DIV, 4, prog_clk half-period in clk cycles (prog_clk = clk/(2*PROG_DIV)); legal range 1..255
MAX_MULT_M1, 8'd31, highest accepted mult_m1; larger requests rejected
TIMEOUT, 20'd1000000, clk cycles allowed in WAIT_DONE plus WAIT_LOCK combined before err

Ports:
clk  in  1  fxclk domain clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE, ignored otherwise
mult_m1  in  8  M-1 (M = 2..256); captured on accepted start
div_m1  in  8  D-1 (D = 1..256); captured on accepted start
busy  out  1  high from accepted start until done/err pulse
done  out  1  one-cycle pulse: reprogram complete and DCM locked
err  out  1  one-cycle pulse: request rejected or timeout
cur_mult_m1  out  8  last successfully programmed M-1
prog_clk  out  1  to DCM PROGCLK
prog_data  out  1  to DCM PROGDATA
prog_en  out  1  to DCM PROGEN
prog_done  in  1  from DCM PROGDONE; 2-flop synchronised internally
dcm_locked  in  1  from DCM LOCKED; 2-flop synchronised internally

Behaviour:
- Reset (reset low, async): state IDLE, busy=0, done=0, err=0, prog_clk=0, prog_data=0, prog_en=0, cur_mult_m1=8'd19, dividers and counters cleared.
- prog_clk: free-running toggle every PROG_DIV clk cycles. All prog_data/prog_en updates, and all state advances after IDLE, occur only on the clk cycle where prog_clk goes 1->0. The DCM therefore samples stable data on the rising edge.
- Accepted start in IDLE:
  - If mult_m1 < 1 or mult_m1 > MAX_MULT_M1: err pulses the next cycle, busy stays 0, no DCM activity.
  - Otherwise: latch mult_m1/div_m1, busy=1, enter LOAD_D.
- LOAD_D: 10 prog_clk bits with prog_en=1; prog_data = 1, 0, then div_m1[0..7] (LSB first).
- GAP1: 2 bits with prog_en=0, prog_data=0.
- LOAD_M: 10 bits with prog_en=1; prog_data = 1, 1, then mult_m1[0..7] (LSB first).
- GAP2: 2 bits with prog_en=0.
- GO: 1 bit with prog_en=1, prog_data=0. Then 1 bit with prog_en=0, then WAIT_DONE.
- WAIT_DONE: wait for synced prog_done=1, then WAIT_LOCK.
- WAIT_LOCK: wait for synced dcm_locked=1. Then cur_mult_m1 <= latched mult_m1, done pulses, busy=0, IDLE.
- Timeout counter starts on GO exit and covers WAIT_DONE + WAIT_LOCK. When it reaches TIMEOUT: err pulses, busy=0, prog_en=0, IDLE, cur_mult_m1 unchanged.
- done and err never assert in the same cycle. Each is exactly one clk wide.
- start while busy: ignored, no queueing.
- Reset asserted mid-sequence: immediate return to reset values, prog_en drops asynchronously. A partial LoadD/LoadM without GO does not change the DCM output.
- A bit counter (4 bits) and a prog_clk divider counter (8 bits) are the only counters besides timeout. The bit counter wraps by reload at each state entry, never by overflow.

Decomposition:
- Shared package dcm_prog_pkg:
  - state enum (IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, GO_GAP, WAIT_DONE, WAIT_LOCK)
  - command prefix constants CMD_LOADD=2'b01, CMD_LOADM=2'b11 (transmit order bit0 first)
  - reset multiplier constant 8'd19
- One sub-module: dcm_prog_shifter, a 10-bit LSB-first shift register with load and shift-on-enable, reused for LoadD and LoadM. The sequencer FSM stays in dcm_prog_ctrl.

Test Plan:
- PROG_DIV=2, start with mult_m1=19, div_m1=5, model asserts prog_done 3 prog_clk after GO and locked 10 cycles later -> prog_data on rising prog_clk edges equals 1,0,1,0,1,0,0,0,0,0 then 1,1,1,1,0,0,1,0,0,0. Exactly one GO bit, done pulse, cur_mult_m1=19.
- start with mult_m1=0, and separately mult_m1=40 (MAX 31) -> err pulse the cycle after start, busy never high, prog_en stays 0.
- Model never returns prog_done, TIMEOUT=500 -> err pulse 500 clk after GO exit, busy=0, cur_mult_m1 unchanged (19).
- Second start pulsed during LOAD_M -> ignored. Serial stream identical to the first request, exactly one done.
- reset low during LOAD_D bit 6 -> prog_en=0 within the same cycle (async), all outputs at reset values. A new request after release completes normally.
- Back-to-back requests mult_m1=10 then 25 -> two complete sequences, two done pulses, cur_mult_m1=10 then 25.
